// File: rtl/friscv_apb_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : friscv_req_if / friscv_apb_if
//  Description : Bus bundles used by friscv_apb_bridge.
//                friscv_req_if - core valid/ready request channel plus the
//                                response beat returned to the core.
//                  master modport : the core (drives req_*, resp_ready)
//                  slave  modport : the bridge (drives req_ready, resp_*)
//                friscv_apb_if - single-outstanding APB-style slave access.
//                  master modport : the bridge (drives mst_en/wr/addr/wdata/strb)
//                  slave  modport : the peripheral (drives mst_rdata/mst_ready)
//  Revision    : 1.0 - initial release
// ============================================================================

interface friscv_req_if #(
    parameter int ADDRW = 16,
    parameter int XLEN  = 32
);
    logic                req_valid;
    logic                req_ready;
    logic                req_wr;
    logic [ADDRW-1:0]    req_addr;
    logic [XLEN-1:0]     req_wdata;
    logic [XLEN/8-1:0]   req_strb;
    logic                resp_valid;
    logic                resp_ready;
    logic [XLEN-1:0]     resp_rdata;
    logic                resp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, req_strb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, req_strb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface friscv_apb_if #(
    parameter int ADDRW = 16,
    parameter int XLEN  = 32
);
    logic                mst_en;
    logic                mst_wr;
    logic [ADDRW-1:0]    mst_addr;
    logic [XLEN-1:0]     mst_wdata;
    logic [XLEN/8-1:0]   mst_strb;
    logic [XLEN-1:0]     mst_rdata;
    logic                mst_ready;

    modport master (
        output mst_en, mst_wr, mst_addr, mst_wdata, mst_strb,
        input  mst_rdata, mst_ready
    );

    modport slave (
        input  mst_en, mst_wr, mst_addr, mst_wdata, mst_strb,
        output mst_rdata, mst_ready
    );
endinterface

`default_nettype wire

// File: rtl/friscv_apb_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : friscv_apb_bridge
//  Description : Upstream master stage for APB-style peripheral slaves.
//                Accepts one core request at a time, runs a single slave
//                access, and returns one response beat. A bus timeout turns
//                a non-responding slave into an error response.
//  Ports       : aclk    - clock
//                aresetn - asynchronous active-low reset
//                srst    - synchronous active-high reset (same effect)
//                req     - core request/response channel (slave side)
//                apb     - peripheral access channel (master side)
//  Parameters  : ADDRW   - address width
//                XLEN    - data width (strobes are XLEN/8 wide)
//                TIMEOUT - max ACCESS cycles without mst_ready, 0 = disabled
//  Revision    : 1.0 - initial release
// ============================================================================

module friscv_apb_bridge #(
    parameter int ADDRW   = 16,
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
)(
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          srst,
    friscv_req_if.slave   req,
    friscv_apb_if.master  apb
);

    // Counter just wide enough to hold TIMEOUT (it saturates there).
    localparam int                  c_CNTW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNTW-1:0]   c_CNT_MAX  = c_CNTW'(TIMEOUT);
    localparam logic [c_CNTW-1:0]   c_CNT_LAST = c_CNTW'(TIMEOUT - 1);
    localparam bit                  c_TO_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t               r_state,      w_state;
    logic                 r_mst_en,     w_mst_en;
    logic                 r_mst_wr,     w_mst_wr;
    logic [ADDRW-1:0]     r_mst_addr,   w_mst_addr;
    logic [XLEN-1:0]      r_mst_wdata,  w_mst_wdata;
    logic [XLEN/8-1:0]    r_mst_strb,   w_mst_strb;
    logic                 r_resp_valid, w_resp_valid;
    logic [XLEN-1:0]      r_resp_rdata, w_resp_rdata;
    logic                 r_resp_err,   w_resp_err;
    logic [c_CNTW-1:0]    r_cnt,        w_cnt;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_mst_en     <= 1'b0;
            r_mst_wr     <= 1'b0;
            r_mst_addr   <= '0;
            r_mst_wdata  <= '0;
            r_mst_strb   <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_cnt        <= '0;
        end else if (srst) begin
            r_state      <= S_IDLE;
            r_mst_en     <= 1'b0;
            r_mst_wr     <= 1'b0;
            r_mst_addr   <= '0;
            r_mst_wdata  <= '0;
            r_mst_strb   <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state;
            r_mst_en     <= w_mst_en;
            r_mst_wr     <= w_mst_wr;
            r_mst_addr   <= w_mst_addr;
            r_mst_wdata  <= w_mst_wdata;
            r_mst_strb   <= w_mst_strb;
            r_resp_valid <= w_resp_valid;
            r_resp_rdata <= w_resp_rdata;
            r_resp_err   <= w_resp_err;
            r_cnt        <= w_cnt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state      = r_state;
        w_mst_en     = r_mst_en;
        w_mst_wr     = r_mst_wr;
        w_mst_addr   = r_mst_addr;
        w_mst_wdata  = r_mst_wdata;
        w_mst_strb   = r_mst_strb;
        w_resp_valid = r_resp_valid;
        w_resp_rdata = r_resp_rdata;
        w_resp_err   = r_resp_err;
        w_cnt        = r_cnt;

        case (r_state)
            S_IDLE: begin
                // req_ready is high in IDLE, so req_valid alone is the handshake.
                if (req.req_valid) begin
                    w_mst_wr    = req.req_wr;
                    w_mst_addr  = req.req_addr;
                    w_mst_wdata = req.req_wdata;
                    w_mst_strb  = req.req_strb;
                    w_mst_en    = 1'b1;
                    w_cnt       = '0;
                    w_state     = S_ACCESS;
                end
            end

            S_ACCESS: begin
                if (!apb.mst_ready && (r_cnt != c_CNT_MAX)) begin
                    w_cnt = r_cnt + 1'b1;
                end
                // Completion has priority over the timeout on the same cycle.
                // mst_en drops at this edge so the slave cannot restart.
                if (apb.mst_ready) begin
                    w_mst_en     = 1'b0;
                    w_resp_rdata = r_mst_wr ? '0 : apb.mst_rdata;
                    w_resp_err   = 1'b0;
                    w_resp_valid = 1'b1;
                    w_state      = S_RESP;
                end else if (c_TO_EN && (r_cnt == c_CNT_LAST)) begin
                    w_mst_en     = 1'b0;
                    w_resp_rdata = '0;
                    w_resp_err   = 1'b1;
                    w_resp_valid = 1'b1;
                    w_state      = S_RESP;
                end
            end

            S_RESP: begin
                if (req.resp_ready) begin
                    w_resp_valid = 1'b0;
                    w_resp_err   = 1'b0;
                    w_state      = S_IDLE;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign req.req_ready  = (r_state == S_IDLE);
    assign req.resp_valid = r_resp_valid;
    assign req.resp_rdata = r_resp_rdata;
    assign req.resp_err   = r_resp_err;

    assign apb.mst_en     = r_mst_en;
    assign apb.mst_wr     = r_mst_wr;
    assign apb.mst_addr   = r_mst_addr;
    assign apb.mst_wdata  = r_mst_wdata;
    assign apb.mst_strb   = r_mst_strb;

endmodule

`default_nettype wire

// File: tb/tb_friscv_apb_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_friscv_apb_bridge
//  Description : Self-checking bench for friscv_apb_bridge. A behavioural
//                4-register slave with programmable response latency sits on
//                the APB side; an independent reference model predicts the
//                response, latency and enable duration of every transaction.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_friscv_apb_bridge;

    localparam int ADDRW   = 16;
    localparam int XLEN    = 32;
    localparam int TIMEOUT = 4;
    localparam int NEVER   = 99;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic srst    = 1'b0;

    always #5 aclk = ~aclk;

    friscv_req_if #(.ADDRW(ADDRW), .XLEN(XLEN)) u_req ();
    friscv_apb_if #(.ADDRW(ADDRW), .XLEN(XLEN)) u_apb ();

    friscv_apb_bridge #(
        .ADDRW   (ADDRW),
        .XLEN    (XLEN),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .srst    (srst),
        .req     (u_req),
        .apb     (u_apb)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural slave: responds s_lat cycles after it first sees mst_en,
    // never when s_lat==NEVER. Emits random mst_ready noise while idle.
    // ------------------------------------------------------------------
    logic [31:0] s_mem [4];
    int          s_lat = 1;

    initial begin
        int s_wait;
        s_wait = 0;
        for (int i = 0; i < 4; i++) s_mem[i] = '0;
        u_apb.mst_ready = 1'b0;
        u_apb.mst_rdata = '0;
        forever begin
            @(posedge aclk);
            #1;
            if (u_apb.mst_en) begin
                if (s_lat != NEVER && s_wait == s_lat) begin
                    u_apb.mst_ready = 1'b1;
                    if (u_apb.mst_wr) begin
                        for (int b = 0; b < 4; b++)
                            if (u_apb.mst_strb[b])
                                s_mem[u_apb.mst_addr[1:0]][8*b +: 8] = u_apb.mst_wdata[8*b +: 8];
                        u_apb.mst_rdata = $urandom;
                    end else begin
                        u_apb.mst_rdata = s_mem[u_apb.mst_addr[1:0]];
                    end
                end else begin
                    u_apb.mst_ready = 1'b0;
                    u_apb.mst_rdata = $urandom;
                end
                s_wait++;
            end else begin
                s_wait = 0;
                u_apb.mst_ready = ($urandom_range(0, 3) == 0);
                u_apb.mst_rdata = $urandom;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: a 4-word byte-addressable register file
    // ------------------------------------------------------------------
    logic [31:0] m_mem [4];

    // Returns expected rdata/err and the number of cycles mst_en is high
    // (equal to the request-to-response latency in cycles).
    task automatic model(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int lat,
                         output logic [31:0] e_rdata, output logic e_err, output int e_cyc);
        if (lat >= TIMEOUT) begin
            e_err   = 1'b1;
            e_rdata = '0;
            e_cyc   = TIMEOUT;
        end else begin
            e_err = 1'b0;
            e_cyc = lat + 1;
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) m_mem[addr[1:0]][8*b +: 8] = wdata[8*b +: 8];
                e_rdata = '0;
            end else begin
                e_rdata = m_mem[addr[1:0]];
            end
        end
    endtask

    // ------------------------------------------------------------------
    // One full transaction: request, access, response with rdly cycles of
    // backpressure (during which a competing request is presented).
    // ------------------------------------------------------------------
    task automatic txn(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int lat, input int rdly);
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_cyc;
        int          cyc;
        int          en_cnt;
        logic [52:0] e_fields;

        model(wr, addr, wdata, strb, lat, e_rdata, e_err, e_cyc);
        e_fields = {wr, addr, strb, wdata};

        @(negedge aclk);
        chk("req_ready_idle", u_req.req_ready, 1);
        s_lat = lat;
        u_req.req_valid = 1'b1;
        u_req.req_wr    = wr;
        u_req.req_addr  = addr;
        u_req.req_wdata = wdata;
        u_req.req_strb  = strb;
        @(negedge aclk);
        u_req.req_valid = 1'b0;
        u_req.req_wr    = ~wr;
        u_req.req_addr  = $urandom;
        u_req.req_wdata = $urandom;
        u_req.req_strb  = $urandom;

        cyc    = 0;
        en_cnt = 0;
        while (!u_req.resp_valid && cyc < 20) begin
            if (u_apb.mst_en) en_cnt++;
            chk("req_ready_busy", u_req.req_ready, 0);
            chk("mst_fields", {u_apb.mst_wr, u_apb.mst_addr, u_apb.mst_strb, u_apb.mst_wdata}, e_fields);
            @(negedge aclk);
            cyc++;
        end
        chk("resp_latency", cyc, e_cyc);
        chk("en_cycles", en_cnt, e_cyc);
        chk("en_low_at_resp", u_apb.mst_en, 0);
        chk("resp_err", u_req.resp_err, e_err);
        chk("resp_rdata", u_req.resp_rdata, e_rdata);
        chk("mst_hold", {u_apb.mst_wr, u_apb.mst_addr, u_apb.mst_strb, u_apb.mst_wdata}, e_fields);

        for (int d = 0; d < rdly; d++) begin
            u_req.resp_ready = 1'b0;
            u_req.req_valid  = 1'b1;
            @(negedge aclk);
            chk("bp_valid", u_req.resp_valid, 1);
            chk("bp_resp", {u_req.resp_err, u_req.resp_rdata}, {e_err, e_rdata});
            chk("bp_req_ready", u_req.req_ready, 0);
            chk("bp_no_access", u_apb.mst_en, 0);
        end
        u_req.resp_ready = 1'b1;
        u_req.req_valid  = (rdly > 0);
        @(negedge aclk);
        u_req.resp_ready = 1'b0;
        u_req.req_valid  = 1'b0;
        chk("resp_done", {u_req.resp_valid, u_req.resp_err}, 2'b00);
        chk("no_same_edge_accept", u_apb.mst_en, 0);
        chk("req_ready_after", u_req.req_ready, 1);
    endtask

    // Reset asserted while an access is outstanding (slave never answers).
    task automatic rst_mid(input bit use_async);
        @(negedge aclk);
        s_lat = NEVER;
        u_req.req_valid = 1'b1;
        u_req.req_wr    = 1'b1;
        u_req.req_addr  = 16'h0003;
        u_req.req_wdata = 32'h1357_9BDF;
        u_req.req_strb  = 4'hF;
        @(negedge aclk);
        u_req.req_valid = 1'b0;
        chk("rst_pre_en", u_apb.mst_en, 1);
        @(negedge aclk);
        if (use_async) begin
            aresetn = 1'b0;
            #1;
            chk("arst_en", u_apb.mst_en, 0);
            chk("arst_valid", u_req.resp_valid, 0);
            chk("arst_ready", u_req.req_ready, 1);
            @(negedge aclk);
            aresetn = 1'b1;
        end else begin
            srst = 1'b1;
            #1;
            chk("srst_en_held", u_apb.mst_en, 1);
            @(negedge aclk);
            srst = 1'b0;
            chk("srst_en", u_apb.mst_en, 0);
            chk("srst_ready", u_req.req_ready, 1);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            chk("rst_no_resp", {u_req.resp_valid, u_apb.mst_en}, 2'b00);
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        u_req.req_valid  = 1'b0;
        u_req.req_wr     = 1'b0;
        u_req.req_addr   = '0;
        u_req.req_wdata  = '0;
        u_req.req_strb   = '0;
        u_req.resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) m_mem[i] = '0;

        repeat (3) @(negedge aclk);
        chk("rst_mst", {u_apb.mst_en, u_apb.mst_wr, u_apb.mst_addr, u_apb.mst_strb, u_apb.mst_wdata}, '0);
        chk("rst_resp", {u_req.resp_valid, u_req.resp_err, u_req.resp_rdata}, '0);
        chk("rst_req_ready", u_req.req_ready, 1);
        aresetn = 1'b1;

        // Full-word write, nominal 1-cycle slave
        txn(1'b1, 16'h0000, 32'hA5A5_1234, 4'hF, 1, 0);
        chk("gpio_out_write", s_mem[0], 32'hA5A5_1234);

        // Read back a known value
        txn(1'b1, 16'h0001, 32'hDEAD_BEEF, 4'hF, 1, 0);
        txn(1'b0, 16'h0001, 32'h0, 4'hF, 1, 0);

        // Partial write over a cleared register, then read it
        txn(1'b1, 16'h0000, 32'h0, 4'hF, 0, 0);
        txn(1'b1, 16'h0000, 32'h0000_FF00, 4'h2, 1, 0);
        chk("gpio_out_partial", s_mem[0], 32'h0000_FF00);
        txn(1'b0, 16'h0000, 32'h0, 4'h0, 2, 0);

        // Response backpressure
        txn(1'b0, 16'h0001, 32'h0, 4'hF, 1, 5);

        // Timeout, then the completion-wins boundary, then normal traffic
        txn(1'b1, 16'h0002, 32'hCAFE_F00D, 4'hF, NEVER, 1);
        chk("timeout_no_write", s_mem[2], 32'h0);
        txn(1'b1, 16'h0002, 32'h1122_3344, 4'hF, TIMEOUT - 1, 0);
        txn(1'b0, 16'h0002, 32'h0, 4'hF, 1, 0);

        // Reset during ACCESS
        rst_mid(1'b1);
        txn(1'b0, 16'h0003, 32'h0, 4'hF, 1, 0);
        rst_mid(1'b0);
        txn(1'b0, 16'h0003, 32'h0, 4'hF, 0, 0);
        chk("rst_no_write", s_mem[3], 32'h0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            int lat;
            lat = $urandom_range(0, 4);
            if (lat == 4) lat = NEVER;
            txn(1'($urandom_range(0, 1)), 16'($urandom), $urandom, 4'($urandom),
                lat, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
